apb_master: RTL

APB bridge that sits directly upstream of the 8-bit APB slave memory. It converts a simple valid/ready command stream into APB transfers (SETUP then ACCESS), waits on PREADY, and returns a one-cycle read/write response. Commands are buffered in a small FIFO so a host can queue bursts, and queued transfers are issued back-to-back.

---
 rtl/apb_master_pkg.sv | 21 ++
 rtl/apb_master_if.sv | 35 +++
 rtl/apb_master_cmd_fifo.sv | 54 +++++
 rtl/apb_master.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB master bridge and its command FIFO.
package apb_master_pkg;

    localparam int APB_ADDR_W    = 8;
    localparam int APB_DATA_W    = 8;
    localparam int APB_CMD_DEPTH = 4;
    localparam int APB_TIMEOUT   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the bridge, bundled with directional modports.
interface apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_cmd_fifo.sv
// Synchronous command FIFO (module apb_cmd_fifo); DEPTH must be a power of two so pointers wrap freely.
module apb_cmd_fifo
    import apb_master_pkg::*;
#(
    parameter int DEPTH = APB_CMD_DEPTH
) (
    input  logic     PCLK,
    input  logic     PRESET,
    input  logic     push,
    input  apb_cmd_t push_cmd,
    input  logic     pop,
    output apb_cmd_t head,
    output logic     full,
    output logic     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    apb_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge PCLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_cmd;
    end

endmodule

// File: rtl/apb_master.sv
// Queued valid/ready to APB bridge; define APB_MASTER_TIMEOUT_EN to abort ACCESS phases
// that see PREADY low for TIMEOUT consecutive cycles.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int DATA_W    = APB_DATA_W,
    parameter int CMD_DEPTH = APB_CMD_DEPTH,
    parameter int TIMEOUT   = APB_TIMEOUT
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);
    apb_state_t        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              pop, full, empty;
    apb_cmd_t          head, push_cmd;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, rsp_err_d;
    assign bus.rsp_err = rsp_err_q;
`else
    logic tmo_unused;
    assign tmo_unused  = (TIMEOUT > 0);
    assign bus.rsp_err = 1'b0;
`endif

    assign push_cmd.write = bus.cmd_write;
    assign push_cmd.addr  = bus.cmd_addr;
    assign push_cmd.wdata = bus.cmd_wdata;

    apb_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .push     (bus.cmd_valid),
        .push_cmd (push_cmd),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        tmo_cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pop       = !empty;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    // Chain straight into the next SETUP when more work is queued.
                    pop       = !empty;
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = head.write;
            paddr_d   = head.addr;
            pwdata_d  = head.wdata;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || (state_q != IDLE);
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
